// File: rtl/maj_tree_pipe.sv
// Pipelined majority-of-3 tree, one register stage per level, LANES trees in parallel.
// Optional per-leaf inversion mask is enabled by defining MAJ_TREE_INV_EN.
`timescale 1ns/1ps
module maj_tree_pipe #(
   parameter int LEVELS = 2,
   parameter int LANES  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*(3**LEVELS)-1:0]  pi,
`ifdef MAJ_TREE_INV_EN
   input  logic [LANES*(3**LEVELS)-1:0]  inv_mask,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0]              po,
   output logic [15:0]                   out_cnt
);

   localparam int LEAVES = 3 ** LEVELS;

   // Bit offset of stage k's register inside the flat stage bus.
   function automatic int soff(input int k);
      int s;
      s = 0;
      for (int i = 0; i < k; i++) s += LANES * (3 ** (LEVELS - 1 - i));
      return s;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   localparam int TOT = soff(LEVELS);

   logic [LANES*LEAVES-1:0] lf;
   logic [TOT-1:0]          sq;
   logic [LEVELS-1:0]       sv;
   logic [LEVELS-1:0]       nv;
   logic [LEVELS-1:0]       ld;
   logic                    dn;
   logic                    pv;

`ifdef MAJ_TREE_INV_EN
   assign lf = pi ^ inv_mask;
`else
   assign lf = pi;
`endif

   // Load chain runs from the output back to the input, so bubbles collapse.
   always_comb begin
      ld = '0;
      dn = out_ready;
      for (int i = LEVELS - 1; i >= 0; i--) begin
         ld[i] = ~sv[i] | dn;
         dn    = ld[i];
      end
   end

   always_comb begin
      nv = sv;
      pv = in_valid;
      for (int i = 0; i < LEVELS; i++) begin
         if (ld[i]) nv[i] = pv;
         pv = sv[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sv <= '0;
      else     sv <= nv;
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_st
      localparam int OW = LANES * (3 ** (LEVELS - 1 - k));
      localparam int IW = 3 * OW;
      logic [IW-1:0] din;
      logic [OW-1:0] nxt;
      logic [OW-1:0] q;
      if (k == 0) begin : g_in
         assign din = lf;
      end else begin : g_mid
         assign din = sq[soff(k-1) +: IW];
      end
      for (genvar j = 0; j < OW; j++) begin : g_n
         assign nxt[j] = maj3(din[3*j], din[3*j+1], din[3*j+2]);
      end
      always_ff @(posedge clk) begin
         if (ld[k]) q <= nxt;
      end
      assign sq[soff(k) +: OW] = q;
   end

   assign in_ready  = ld[0];
   assign out_valid = sv[LEVELS-1];
   assign po        = sq[soff(LEVELS-1) +: LANES];

   always_ff @(posedge clk) begin
      if (rst)                         out_cnt <= '0;
      else if (out_valid && out_ready) out_cnt <= out_cnt + 16'd1;
   end

endmodule

// File: tb/tb_maj_tree_pipe.sv
// Directed bench for maj_tree_pipe: LEVELS=2/LANES=1 main instance
// plus a LEVELS=1/LANES=2 instance for lane independence.
`timescale 1ns/1ps
module tb_maj_tree_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  pi;
   logic [8:0]  inv_mask;
   logic        out_valid;
   logic        out_ready;
   logic [0:0]  po;
   logic [15:0] out_cnt;

   logic        iv2;
   logic        ir2;
   logic [5:0]  pi2;
   logic [5:0]  msk2;
   logic        ov2;
   logic [1:0]  po2;
   logic [15:0] cnt2;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [8:0] A = 9'b000_011_011;
   localparam logic [8:0] B = 9'b000_000_111;
   localparam logic [8:0] C = 9'b111_111_000;

   always #5 clk = ~clk;

   maj_tree_pipe #(.LEVELS(2), .LANES(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pi(pi),
`ifdef MAJ_TREE_INV_EN
      .inv_mask(inv_mask),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .po(po), .out_cnt(out_cnt)
   );

   maj_tree_pipe #(.LEVELS(1), .LANES(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
      .pi(pi2),
`ifdef MAJ_TREE_INV_EN
      .inv_mask(msk2),
`endif
      .out_valid(ov2), .out_ready(1'b1), .po(po2), .out_cnt(cnt2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic one(input logic [8:0] v, input logic e, input string tag);
      pi = v;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_po"}, {31'd0, po}, {31'd0, e});
      tick;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      pi = '0; inv_mask = '0; iv2 = 1'b0; pi2 = '0; msk2 = '0;
      tick;
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_cnt", {16'd0, out_cnt}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ir", {31'd0, in_ready}, 32'd1);

      // single transfer: out_valid two edges after presentation
      pi = A; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("lat_early", {31'd0, out_valid}, 32'd0);
      tick;
      chk("lat_ov", {31'd0, out_valid}, 32'd1);
      chk("lat_po", {31'd0, po}, 32'd1);
      tick;
      chk("lat_cnt", {16'd0, out_cnt}, 32'd1);
      chk("lat_drain", {31'd0, out_valid}, 32'd0);

      one(B, 1'b0, "vecB");
      one(C, 1'b1, "vecC");

      // stall: both stages fill, third input waits
      out_ready = 1'b0;
      pi = A; in_valid = 1'b1;
      #1;
      chk("st_ir0", {31'd0, in_ready}, 32'd1);
      tick;
      chk("st_ir1", {31'd0, in_ready}, 32'd1);
      pi = B;
      tick;
      chk("st_ir2", {31'd0, in_ready}, 32'd0);
      chk("st_ov", {31'd0, out_valid}, 32'd1);
      chk("st_poA", {31'd0, po}, 32'd1);
      pi = C;
      tick;
      tick;
      chk("st_hold", {31'd0, po}, 32'd1);
      chk("st_ir3", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("st_ir4", {31'd0, in_ready}, 32'd1);
      tick;
      in_valid = 1'b0;
      chk("dr_ovB", {31'd0, out_valid}, 32'd1);
      chk("dr_poB", {31'd0, po}, 32'd0);
      tick;
      chk("dr_ovC", {31'd0, out_valid}, 32'd1);
      chk("dr_poC", {31'd0, po}, 32'd1);
      tick;
      chk("dr_end", {31'd0, out_valid}, 32'd0);
      chk("dr_cnt", {16'd0, out_cnt}, 32'd6);

      // reset with two results in flight
      out_ready = 1'b0;
      pi = C; in_valid = 1'b1;
      tick;
      tick;
      in_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mr_ov", {31'd0, out_valid}, 32'd0);
      chk("mr_cnt", {16'd0, out_cnt}, 32'd0);
      chk("mr_ir", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("mr_stale", {31'd0, out_valid}, 32'd0);
      end

      // lane independence on the LEVELS=1, LANES=2 instance
      pi2 = 6'b011_001; iv2 = 1'b1;
      tick;
      iv2 = 1'b0;
      chk("ln_ov", {31'd0, ov2}, 32'd1);
      chk("ln_po", {30'd0, po2}, 32'd2);
`ifdef MAJ_TREE_INV_EN
      tick;
      pi2 = 6'b000_000; msk2 = 6'b000_011; iv2 = 1'b1;
      tick;
      iv2 = 1'b0;
      chk("inv_po", {30'd0, po2}, 32'd1);
`endif

      // stream 65535 inputs, then one more to wrap out_cnt
      pi = A; in_valid = 1'b1;
      for (int i = 1; i <= 65535; i++) begin
         tick;
         if (i == 100) chk("thru", {16'd0, out_cnt}, 32'd98);
      end
      in_valid = 1'b0;
      tick;
      tick;
      chk("cnt_max", {16'd0, out_cnt}, 32'hFFFF);
      one(B, 1'b0, "wrapv");
      chk("cnt_wrap", {16'd0, out_cnt}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/maj_tree_pipe.md
MAJ_TREE_PIPE -- requirements
Module: maj_tree_pipe

Interface
- REQ-001: Parameter LEVELS, default 2: number of majority-of-3 tree levels; legal range 1-4.
- REQ-002: Parameter LANES, default 1: number of independent trees evaluated in parallel; legal range 1-8.
- REQ-003: Derived constant LEAVES = 3^LEVELS, the leaves per lane.
- REQ-004: clk  in  1  the single clock; all state updates on its rising edge.
- REQ-005: rst  in  1  reset, synchronous, active-high.
- REQ-006: in_valid  in  1  the input vector is valid.
- REQ-007: in_ready  out  1  the block accepts the input this cycle.
- REQ-008: pi  in  LANES*LEAVES  leaf inputs; lane L occupies bits [L*LEAVES +: LEAVES].
- REQ-009: inv_mask  in  LANES*LEAVES  per-leaf inversion; the port is present only under MAJ_TREE_INV_EN.
- REQ-010: out_valid  out  1  po holds a result.
- REQ-011: out_ready  in  1  the consumer takes the result.
- REQ-012: po  out  LANES  one majority result per lane.
- REQ-013: out_cnt  out  16  count of results delivered.

Function
- REQ-014: Level-1 node j of a lane SHALL be MAJ(leaf[3j], leaf[3j+1], leaf[3j+2]); level-k node j SHALL be MAJ of level-(k-1) nodes 3j, 3j+1 and 3j+2; po[L] SHALL be the single level-LEVELS node of lane L.
- REQ-015: MAJ(a,b,c) SHALL be (a&b)|(a&c)|(b&c).
- REQ-016: Each tree level SHALL be one pipeline stage with its own register and valid bit; stage LEVELS SHALL drive po and out_valid.
- REQ-017: Latency with no stall SHALL be exactly LEVELS cycles from the accepting edge to out_valid=1.
- REQ-018: An input transfer occurs on a rising edge with in_valid=1 and in_ready=1; an output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
- REQ-019: Stage k SHALL load when it is empty, or when stage k+1 loads in the same cycle (for the last stage, when the output transfers); otherwise it SHALL hold.
- REQ-020: in_ready SHALL equal the load condition of stage 1; it SHALL be combinational from out_ready and the stage valids only, never from in_valid.
- REQ-021: Bubbles SHALL collapse: an empty stage SHALL load even while a downstream stage stalls.
- REQ-022: With out_ready held at 1 and in_valid held at 1, throughput SHALL be one result per cycle.
- REQ-023: po SHALL remain stable while out_valid=1 and out_ready=0.
- REQ-024: out_cnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
- REQ-025: An input and an output transfer in the same cycle SHALL both complete, with no loss or duplication.
- REQ-026: When LANES>1, all lanes SHALL share one handshake; the lanes differ only in data.

Reset
- REQ-027: While rst=1, all stage valid bits, out_valid and out_cnt SHALL be 0 at the next edge, and in_ready SHALL read 1 in the cycle after.
- REQ-028: Stage data registers need no reset; po SHALL be ignored while out_valid=0.
- REQ-029: Assertion of rst mid-operation SHALL discard all in-flight results, with no output transfer for them.

Configuration
- REQ-030: Macro MAJ_TREE_INV_EN defined: the inv_mask port SHALL exist and each leaf SHALL be pi XOR inv_mask, sampled on the input transfer.
- REQ-031: MAJ_TREE_INV_EN undefined: there SHALL be no inv_mask port and each leaf SHALL equal pi directly.

Verification
- REQ-032: LEVELS=2, LANES=1, pi=9'b000_011_011, single transfer, out_ready=1 -> out_valid=1 exactly 2 cycles later, po=1, out_cnt=1.
- REQ-033: LEVELS=2, pi=9'b000_000_111 -> po=0; pi=9'b111_111_000 -> po=1.
- REQ-034: LEVELS=2, 3 back-to-back inputs with out_ready=0 -> in_ready falls after both stages fill; out_ready=1 then drains 3 results in order, one per cycle, with po stable during the stall.
- REQ-035: out_cnt preloaded to 0xFFFF via 65535 transfers, then one more transfer -> out_cnt=0x0000.
- REQ-036: rst asserted for one cycle with 2 results in flight -> out_valid=0 and out_cnt=0 the next cycle, and no stale result appears afterwards.
- REQ-037: MAJ_TREE_INV_EN defined, LEVELS=1, pi=3'b000, inv_mask=3'b011 -> po=1; LANES=2 lanes checked independently.
